// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types and constants for the two-port memory request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Arbiter FSM: idle, or one transaction in flight for the named owner.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  // Owner of the in-flight transaction, used to steer the response.
  localparam logic ARB_OWNER_INST = 1'b0;
  localparam logic ARB_OWNER_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: merges the fetch read port and the load/store port onto one memory port.
// Latency: strobe one cycle after the request is seen in IDLE; response steered back combinationally.
// Backpressure: requests are held until *_resp; one transaction at a time, one IDLE cycle between.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   inst_read/inst_address       fetch request (level) and byte address
//   inst_rdata/inst_resp         fetch data and completion pulse
//   data_read/data_write         load/store request (level), write wins if both
//   data_address/wdata/wmask     load/store address, store data and byte enables
//   data_rdata/data_resp         load data and completion pulse
//   mem_read/mem_write           registered downstream strobes
//   mem_address/wdata/wmask      registered downstream command, latched at grant
//   mem_rdata/mem_resp           downstream read data and completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_address,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wmask,
  output logic [31:0] data_rdata,
  output logic        data_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  // Counter must hold MAX_DATA_STREAK itself; never narrower than 3 bits.
  localparam int STREAK_W = ($clog2(MAX_DATA_STREAK + 1) < 3) ? 3 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;

  logic data_req;
  logic grant_data;
  logic owner;
  logic done;

  assign data_req   = data_read | data_write;
  // Data wins unless it has already taken its quota while fetch waits.
  assign grant_data = data_req & ((streak < STREAK_MAX) | ~inst_read);

  assign owner = (state == ARB_DATA) ? ARB_OWNER_DATA : ARB_OWNER_INST;
  // mem_resp only completes a transaction that is actually in flight;
  // a stray one in IDLE is dropped, and nothing is reported during reset.
  assign done  = rst & (state != ARB_IDLE) & mem_resp;

  assign inst_resp  = done & (owner == ARB_OWNER_INST);
  assign data_resp  = done & (owner == ARB_OWNER_DATA);
  assign inst_rdata = inst_resp ? mem_rdata : 32'h0;
  assign data_rdata = data_resp ? mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      streak      <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wmask   <= 4'h0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            state       <= ARB_DATA;
            // Both strobes high is illegal upstream; treat it as a store.
            mem_read    <= ~data_write;
            mem_write   <= data_write;
            mem_address <= data_address;
            mem_wdata   <= data_write ? data_wdata : 32'h0;
            mem_wmask   <= data_write ? data_wmask : 4'h0;
            // Only grants that make fetch wait count toward the streak.
            if (!inst_read)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + STREAK_W'(1);
          end else if (inst_read) begin
            state       <= ARB_INST;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= inst_address & ~32'h3;
            mem_wdata   <= 32'h0;
            mem_wmask   <= 4'h0;
            streak      <= '0;
          end else begin
            streak <= '0;
          end
        end
        ARB_INST, ARB_DATA: begin
          // Command registers stay frozen; only completion moves us on.
          if (mem_resp) begin
            state     <= ARB_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_address;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_wdata;
  logic [3:0]  data_wmask;
  logic [31:0] data_rdata;
  logic        data_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_chk;
  int n_fail;

  mem_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_address (inst_address),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_address (data_address),
    .data_wdata   (data_wdata),
    .data_wmask   (data_wmask),
    .data_rdata   (data_rdata),
    .data_resp    (data_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loads and stores at once is a protocol violation by the requester.
  always @(posedge clk)
    if (rst === 1'b1 && data_read === 1'b1 && data_write === 1'b1)
      $error("illegal: data_read and data_write both high");

  // ---------------------------------------------------------------
  // Reference model: one outstanding transaction record plus a count of
  // data grants issued while fetch was waiting.
  // ---------------------------------------------------------------
  typedef struct {
    bit          valid;
    bit          is_data;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  txn_t cur;
  int   data_run;

  task automatic model_reset();
    cur.valid    = 1'b0;
    cur.is_data  = 1'b0;
    cur.is_write = 1'b0;
    cur.addr     = 32'h0;
    cur.wdata    = 32'h0;
    cur.wmask    = 4'h0;
    data_run     = 0;
  endtask

  // Applied once per rising edge with the inputs present at that edge.
  task automatic model_step();
    bit want_data;
    if (!rst) begin
      model_reset();
    end else if (cur.valid) begin
      if (mem_resp) cur.valid = 1'b0;
    end else begin
      want_data = data_read || data_write;
      if (want_data && (data_run < MAX_STREAK || !inst_read)) begin
        cur.valid    = 1'b1;
        cur.is_data  = 1'b1;
        cur.is_write = data_write;
        cur.addr     = data_address;
        cur.wdata    = data_write ? data_wdata : 32'h0;
        cur.wmask    = data_write ? data_wmask : 4'h0;
        data_run     = inst_read ? data_run + 1 : 0;
      end else if (inst_read) begin
        cur.valid    = 1'b1;
        cur.is_data  = 1'b0;
        cur.is_write = 1'b0;
        cur.addr     = {inst_address[31:2], 2'b00};
        cur.wdata    = 32'h0;
        cur.wmask    = 4'h0;
        data_run     = 0;
      end else begin
        data_run = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit fin, fin_i, fin_d;
    fin   = rst && cur.valid && mem_resp;
    fin_i = fin && !cur.is_data;
    fin_d = fin && cur.is_data;
    check("mem_read",    mem_read,    cur.valid && !cur.is_write);
    check("mem_write",   mem_write,   cur.valid && cur.is_write);
    check("mem_address", mem_address, cur.addr);
    check("mem_wdata",   mem_wdata,   cur.wdata);
    check("mem_wmask",   mem_wmask,   cur.wmask);
    check("inst_resp",   inst_resp,   fin_i);
    check("data_resp",   data_resp,   fin_d);
    check("inst_rdata",  inst_rdata,  fin_i ? mem_rdata : 32'h0);
    check("data_rdata",  data_rdata,  fin_d ? mem_rdata : 32'h0);
  endtask

  // Inputs are changed only just after a rising edge; outputs are
  // examined 1-2 time units later, well away from the next edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    inst_read  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    mem_resp   = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    rst          = 1'b0;
    inst_read    = 1'b0;
    inst_address = 32'h0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    data_address = 32'h0;
    data_wdata   = 32'h0;
    data_wmask   = 4'h0;
    mem_rdata    = 32'h0;
    mem_resp     = 1'b0;

    // Reset state
    cycle();
    cycle();
    check("rst_mem_read",    mem_read,    32'h0);
    check("rst_mem_write",   mem_write,   32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    rst = 1'b1;
    cycle();

    // Instruction read only, 10 cycles to respond
    inst_read    = 1'b1;
    inst_address = 32'hABCD1236;
    cycle();
    check("ird_strobe", mem_read,    32'h1);
    check("ird_addr",   mem_address, 32'hABCD1234);
    repeat (9) cycle();
    mem_resp  = 1'b1;
    mem_rdata = 32'h00000013;
    settle();
    check("ird_resp",  inst_resp,  32'h1);
    check("ird_rdata", inst_rdata, 32'h00000013);
    cycle();
    idle_inputs();
    settle();
    check("ird_after", mem_read, 32'h0);
    cycle();

    // Simultaneous requests: data first, fetch after one IDLE cycle
    inst_read    = 1'b1;
    inst_address = 32'h00000400;
    data_read    = 1'b1;
    data_address = 32'h00001000;
    cycle();
    check("sim_first_addr", mem_address, 32'h00001000);
    check("sim_first_rd",   mem_read,    32'h1);
    mem_resp  = 1'b1;
    mem_rdata = 32'h12345678;
    settle();
    check("sim_data_resp",  data_resp,  32'h1);
    check("sim_data_rdata", data_rdata, 32'h12345678);
    check("sim_no_iresp",   inst_resp,  32'h0);
    cycle();
    data_read = 1'b0;
    mem_resp  = 1'b0;
    settle();
    check("sim_idle_gap", mem_read, 32'h0);
    cycle();
    check("sim_inst_addr", mem_address, 32'h00000400);
    check("sim_inst_rd",   mem_read,    32'h1);
    mem_resp = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Store: latched values survive input changes mid-transaction
    data_write   = 1'b1;
    data_address = 32'h00002004;
    data_wdata   = 32'hDEADBEEF;
    data_wmask   = 4'b0011;
    cycle();
    check("st_write", mem_write,   32'h1);
    check("st_read",  mem_read,    32'h0);
    check("st_addr",  mem_address, 32'h00002004);
    check("st_wdata", mem_wdata,   32'hDEADBEEF);
    check("st_wmask", mem_wmask,   32'h3);
    data_wdata   = 32'h0BADF00D;
    data_address = 32'h00009990;
    cycle();
    check("st_wdata_hold", mem_wdata,   32'hDEADBEEF);
    check("st_addr_hold",  mem_address, 32'h00002004);
    mem_resp = 1'b1;
    settle();
    check("st_resp", data_resp, 32'h1);
    cycle();
    idle_inputs();
    cycle();

    // Starvation bound: 4 data grants, then fetch, then data again
    inst_read    = 1'b1;
    inst_address = 32'h00000100;
    data_read    = 1'b1;
    data_address = 32'h00003000;
    for (int g = 0; g < 7; g++) begin
      cycle();
      check($sformatf("streak_grant%0d", g), mem_address,
            (g == MAX_STREAK) ? 32'h00000100 : 32'h00003000);
      mem_resp = 1'b1;
      cycle();
      mem_resp = 1'b0;
    end
    idle_inputs();
    cycle();

    // Reset in the 5th cycle of a fetch: dropped, no response
    inst_read    = 1'b1;
    inst_address = 32'h00004008;
    cycle();
    repeat (4) cycle();
    rst      = 1'b0;
    mem_resp = 1'b1;
    settle();
    check("mrst_no_iresp", inst_resp,  32'h0);
    check("mrst_rdata0",   inst_rdata, 32'h0);
    cycle();
    check("mrst_rd",   mem_read,    32'h0);
    check("mrst_addr", mem_address, 32'h0);
    rst = 1'b1;
    idle_inputs();
    cycle();

    // Stale mem_resp in IDLE
    mem_resp  = 1'b1;
    mem_rdata = 32'hFFFF0000;
    settle();
    check("stale_iresp", inst_resp, 32'h0);
    check("stale_dresp", data_resp, 32'h0);
    cycle();
    check("stale_rd", mem_read,  32'h0);
    check("stale_wr", mem_write, 32'h0);
    mem_resp = 1'b0;
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int dk;
      rst          = ($urandom_range(0, 99) >= 2);
      inst_read    = ($urandom_range(0, 99) < 60);
      inst_address = $urandom;
      dk           = $urandom_range(0, 2);
      data_read    = (dk == 1);
      data_write   = (dk == 2);
      data_address = $urandom;
      data_wdata   = $urandom;
      data_wmask   = 4'($urandom);
      mem_rdata    = $urandom;
      mem_resp     = ($urandom_range(0, 99) < 35);
      settle();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request arbiter between the pipeline and the prefetcher. It merges the fetch stage's instruction-read port and the memory stage's data read/write port into the single memory port the prefetcher consumes (`mem_address`/`mem_read` → `cpu_resp`). It routes the response back to the port that owns the transaction. Data has priority, with a bounded streak so fetch is never starved.

## Interface
Parameters:
- `MAX_DATA_STREAK`, 4: maximum consecutive data grants while an instruction request waits.

Ports (`rst` is synchronous, active-low):
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous active-low reset; 0 = reset.
- `inst_read`  in  1  fetch request, level; held until `inst_resp`.
- `inst_address`  in  32  fetch byte address.
- `inst_rdata`  out  32  fetch read data; valid only with `inst_resp`.
- `inst_resp`  out  1  one-cycle completion pulse for the fetch port.
- `data_read`  in  1  load request, level; held until `data_resp`.
- `data_write`  in  1  store request, level; held until `data_resp`.
- `data_address`  in  32  load/store byte address.
- `data_wdata`  in  32  store data.
- `data_wmask`  in  4  store byte enables.
- `data_rdata`  out  32  load data; valid only with `data_resp`.
- `data_resp`  out  1  one-cycle completion pulse for the data port.
- `mem_read`  out  1  downstream read strobe, registered.
- `mem_write`  out  1  downstream write strobe, registered.
- `mem_address`  out  32  downstream address, registered at grant.
- `mem_wdata`  out  32  downstream write data, registered at grant.
- `mem_wmask`  out  4  downstream byte enables, registered at grant.
- `mem_rdata`  in  32  downstream read data.
- `mem_resp`  in  1  downstream completion; wired to the prefetcher's `cpu_resp`.

## Operation
- The FSM has three states: IDLE, INST, DATA.
- IDLE:
  - If `data_read | data_write` is pending and (`streak < MAX_DATA_STREAK` or no inst request), grant DATA.
  - Else, if `inst_read` is pending, grant INST.
  - Else, stay in IDLE.
- Grant latches the owner's address, wdata and wmask into the `mem_*` registers:
  - `mem_address` gets `inst_address & ~32'h3` for INST; `data_address` is forwarded unmodified.
  - `mem_wdata` and `mem_wmask` are 0 for INST and for data reads.
- INST/DATA: hold all `mem_*` outputs constant. Requester input changes are ignored until completion.
- On `mem_resp`=1 in INST/DATA:
  - Assert the owner's `*_resp` combinationally in the same cycle.
  - Drive `*_rdata` = `mem_rdata` combinationally in the same cycle.
  - Go to IDLE next cycle, with `mem_read`/`mem_write` low.
- Streak counter (3 bits minimum, saturating at `MAX_DATA_STREAK`):
  - Increments on each DATA grant made while `inst_read`=1.
  - Clears on every INST grant and whenever `inst_read`=0 in IDLE.
- `data_read` and `data_write` both high: treated as a write. A bench assertion flags it as illegal.
- `mem_resp` in IDLE is stale. It is ignored; no `*_resp` is raised and state is unchanged.
- Reset (`rst`=0, any state) forces, at the next edge:
  - state = IDLE, streak = 0;
  - `mem_read` = 0, `mem_write` = 0;
  - `mem_address`, `mem_wdata`, `mem_wmask` = 0.

  An in-flight transaction is dropped without a response. `inst_resp`/`data_resp`/`*_rdata` are 0 while `rst`=0.

## Timing
- A request first seen in IDLE at edge N drives `mem_read`/`mem_write` high after edge N (one-cycle grant latency).
- A downstream strobe stays high every cycle until the `mem_resp` cycle inclusive. It is low in the cycle after.
- A requester must drop its request in the cycle after its `*_resp`. A still-high request in that cycle is treated as a new request and re-arbitrated in IDLE.
- Back-to-back minimum spacing: one IDLE cycle between consecutive transactions.
- Zero-wait downstream: `mem_resp` in the first strobe cycle gives 2 cycles request-to-response.

## Structure
- Shared package `mem_arbiter_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_INST, ARB_DATA} arb_state_t`;
  - `ARB_OWNER_INST`/`ARB_OWNER_DATA` constants.
- Single module with no sub-module. FSM, streak counter and grant registers are inline.

## Test plan
- Instruction read only: reset, then `inst_read`=1 with `inst_address`=`32'hABCD1236`, `mem_resp` after 10 cycles with `mem_rdata`=`32'h00000013`.
  - Expect `mem_read`=1 with `mem_address`=`32'hABCD1234` one cycle later.
  - Expect `inst_resp`=1 and `inst_rdata`=`32'h00000013` in the resp cycle.
  - Expect `mem_read`=0 the next cycle.
- Simultaneous requests: `inst_read` and `data_read` (`32'h00001000`) in the same cycle.
  - Expect DATA granted first (`mem_address`=`32'h00001000`).
  - After `data_resp`, expect INST granted after one IDLE cycle.
- Store: `data_write`=1, `data_address`=`32'h00002004`, `data_wdata`=`32'hDEADBEEF`, `data_wmask`=`4'b0011`.
  - Expect `mem_write`=1 with the same values latched.
  - Expect `mem_wdata` unchanged when `data_wdata` is toggled mid-transaction.
- Starvation bound: `inst_read` held and data requests continuously re-asserted.
  - Expect exactly 4 DATA grants, then an INST grant, then the streak restarts.
- Reset mid-transaction: `rst`=0 in the 5th cycle of an INST transaction.
  - Expect `mem_read`=0 and `mem_address`=0 after the next edge, with no `inst_resp`.
- Stale `mem_resp` asserted in IDLE: expect no `*_resp` and no state change.
